// File: rtl/cfg_cmd_responder.sv
// Configuration command endpoint: queues 64-bit commands, executes register
// reads/writes for one module ID and returns a result word per command.
module cfg_cmd_responder #(
   parameter logic [6:0]  MDID     = 7'd1,
   parameter int          NUM_REGS = 16,
   parameter logic [31:0] VERSION  = 32'h2020_0924
) (
   input  logic                     i_sys_clk,
   input  logic                     i_sys_rst,
   input  logic                     i_command_wr,
   input  logic [63:0]              i_command,
   output logic                     o_command_alf,
   output logic                     o_result_wr,
   output logic [63:0]              o_result,
   input  logic                     i_result_alf,
   output logic [NUM_REGS*32-1:0]   o_cfg_regs,
   output logic [31:0]              o_cmd_cnt,
   output logic [31:0]              o_res_cnt,
   output logic [31:0]              o_drop_cnt
);

   localparam int          AW         = $clog2(NUM_REGS);
   localparam logic [19:0] NUM_REGS_A = 20'(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_r;
   logic [63:0]     cmd_r;
   logic [31:0]     regs_r [NUM_REGS];

   logic [63:0]     fifo_mem_r [4];
   logic [1:0]      wr_ptr_r;
   logic [1:0]      rd_ptr_r;
   logic [2:0]      count_r;

   logic            pop_s;
   logic            push_s;
   logic            drop_s;
   logic [19:0]     addr_s;
   logic [AW-1:0]   idx_s;
   logic            is_wr_s;
   logic            ok_s;
   logic [31:0]     rd_val_s;
   logic [63:0]     res_s;

   // FIFO handshake; a pop in the same cycle frees a slot for the incoming word
   always_comb begin
      pop_s  = (state_r == IDLE) && (count_r != 3'd0) && !i_result_alf;
      push_s = i_command_wr && ((count_r != 3'd4) || pop_s);
      drop_s = i_command_wr && !push_s;
   end

   assign o_command_alf = (count_r >= 3'd3);

   // Command FIFO storage, pointers and the accept/drop counters
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         wr_ptr_r   <= 2'd0;
         rd_ptr_r   <= 2'd0;
         count_r    <= 3'd0;
         o_cmd_cnt  <= 32'd0;
         o_drop_cnt <= 32'd0;
         for (int i = 0; i < 4; i++) begin
            fifo_mem_r[i] <= 64'd0;
         end
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= i_command;
            wr_ptr_r             <= wr_ptr_r + 2'd1;
            o_cmd_cnt            <= o_cmd_cnt + 32'd1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 2'd1;
         end
         if (drop_s) begin
            o_drop_cnt <= o_drop_cnt + 32'd1;
         end
         count_r <= count_r + {2'b00, push_s} - {2'b00, pop_s};
      end
   end

   // Decode of the command being executed and the result it produces
   always_comb begin
      addr_s  = cmd_r[51:32];
      idx_s   = cmd_r[32 +: AW];
      is_wr_s = cmd_r[59];
      ok_s    = (cmd_r[58:52] == MDID) && (addr_s < NUM_REGS_A) &&
                !(is_wr_s && (addr_s < 20'd2));
      rd_val_s = regs_r[idx_s];
      if (addr_s == 20'd0) begin
         rd_val_s = VERSION;
      end else if (addr_s == 20'd1) begin
         rd_val_s = o_cmd_cnt;
      end else begin
         rd_val_s = regs_r[idx_s];
      end
      if (ok_s && !is_wr_s) begin
         res_s = {cmd_r[63:61], 1'b1, cmd_r[59:32], rd_val_s};
      end else begin
         res_s = {cmd_r[63:61], ok_s, cmd_r[59:32], cmd_r[31:0]};
      end
   end

   // Control FSM: pop, execute against the register bank, issue the result
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state_r     <= IDLE;
         cmd_r       <= 64'd0;
         o_result_wr <= 1'b0;
         o_result    <= 64'd0;
         o_res_cnt   <= 32'd0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= 32'd0;
         end
      end else begin
         case (state_r)
            IDLE: begin
               o_result_wr <= 1'b0;
               if (pop_s) begin
                  cmd_r   <= fifo_mem_r[rd_ptr_r];
                  state_r <= EXEC;
               end else begin
                  state_r <= IDLE;
               end
            end
            EXEC: begin
               o_result    <= res_s;
               o_result_wr <= 1'b1;
               o_res_cnt   <= o_res_cnt + 32'd1;
               if (ok_s && is_wr_s) begin
                  regs_r[idx_s] <= cmd_r[31:0];
               end
               state_r <= RESP;
            end
            RESP: begin
               o_result_wr <= 1'b0;
               state_r     <= IDLE;
            end
            default: begin
               o_result_wr <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   // Flat register view; slots 0 and 1 are the live read-only values
   always_comb begin
      o_cfg_regs = '0;
      for (int n = 0; n < NUM_REGS; n++) begin
         if (n == 0) begin
            o_cfg_regs[n*32 +: 32] = VERSION;
         end else if (n == 1) begin
            o_cfg_regs[n*32 +: 32] = o_cmd_cnt;
         end else begin
            o_cfg_regs[n*32 +: 32] = regs_r[n];
         end
      end
   end

endmodule

// File: tb/tb_cfg_cmd_responder.sv
// Self-checking bench for cfg_cmd_responder: queue-based reference model
// compared every cycle, plus directed commands with hand-computed results.
module tb_cfg_cmd_responder;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_wr = 1'b0;
   logic [63:0]   cmd = 64'd0;
   logic          res_alf = 1'b0;
   logic          command_alf;
   logic          result_wr;
   logic [63:0]   result;
   logic [511:0]  cfg_regs;
   logic [31:0]   cmd_cnt, res_cnt, drop_cnt;

   cfg_cmd_responder #(.MDID(7'd1), .NUM_REGS(16), .VERSION(32'h2020_0924)) dut (
      .i_sys_clk(clk), .i_sys_rst(rst), .i_command_wr(cmd_wr), .i_command(cmd),
      .o_command_alf(command_alf), .o_result_wr(result_wr), .o_result(result),
      .i_result_alf(res_alf), .o_cfg_regs(cfg_regs), .o_cmd_cnt(cmd_cnt),
      .o_res_cnt(res_cnt), .o_drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_bus(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [2:0] h, input logic st, input logic w,
                                      input logic [6:0] id, input logic [19:0] a,
                                      input logic [31:0] d);
      return {h, st, w, id, a, d};
   endfunction

   // ---------------- reference model ----------------
   logic [63:0] m_fifo[$];
   int          m_stage;        // 0 waiting, 1 executing, 2 answering
   logic [63:0] m_cur;
   logic [31:0] m_regs [16];
   logic [31:0] m_cmd_cnt, m_res_cnt, m_drop;
   logic        m_wr;
   logic [63:0] m_res;

   task automatic respond(input logic [63:0] c, output logic [63:0] r);
      logic        ok;
      logic [31:0] d;
      ok = (c[58:52] == 7'd1) && (c[51:32] < 20'd16) && !(c[59] && c[51:32] < 20'd2);
      d  = c[31:0];
      if (ok && !c[59]) begin
         if (c[51:32] == 20'd0)      d = 32'h2020_0924;
         else if (c[51:32] == 20'd1) d = m_cmd_cnt;
         else                        d = m_regs[c[35:32]];
      end
      if (ok && c[59]) m_regs[c[35:32]] = c[31:0];
      r = {c[63:61], ok, c[59:32], d};
   endtask

   initial begin
      bit pop, acc;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_fifo.delete();
            m_stage = 0; m_cur = 64'd0; m_wr = 1'b0; m_res = 64'd0;
            m_cmd_cnt = 32'd0; m_res_cnt = 32'd0; m_drop = 32'd0;
            for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
         end else begin
            pop  = (m_stage == 0) && (m_fifo.size() > 0) && !res_alf;
            acc  = cmd_wr && ((m_fifo.size() < 4) || pop);
            m_wr = 1'b0;
            if (m_stage == 2) m_stage = 0;
            else if (m_stage == 1) begin
               respond(m_cur, m_res);
               m_wr = 1'b1; m_res_cnt++; m_stage = 2;
            end else if (pop) begin
               m_cur = m_fifo.pop_front(); m_stage = 1;
            end
            if (acc) begin m_fifo.push_back(cmd); m_cmd_cnt++; end
            else if (cmd_wr) m_drop++;
         end
      end
   end

   // ---------------- per-cycle compare + result capture ----------------
   logic [63:0] res_q[$];
   int          res_cyc[$];

   initial begin
      logic [511:0] mb;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("result_wr", 64'(result_wr), 64'(m_wr));
            if (m_wr) chk("result", result, m_res);
            chk("cmd_cnt", 64'(cmd_cnt), 64'(m_cmd_cnt));
            chk("res_cnt", 64'(res_cnt), 64'(m_res_cnt));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            chk("command_alf", 64'(command_alf), 64'(m_fifo.size() >= 3));
            for (int n = 0; n < 16; n++)
               mb[n*32 +: 32] = (n == 0) ? 32'h2020_0924 : (n == 1) ? m_cmd_cnt : m_regs[n];
            chk_bus("cfg_regs", cfg_regs, mb);
            if (result_wr) begin
               res_q.push_back(result);
               res_cyc.push_back(cyc);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic push1(input logic [63:0] c, output int pc);
      @(posedge clk); #1;
      cmd_wr = 1'b1; cmd = c; pc = cyc;
      @(posedge clk); #1;
      cmd_wr = 1'b0;
   endtask

   task automatic wait_res(input int n, input string nm);
      for (int i = 0; i < 60 && res_q.size() < n; i++) begin
         @(negedge clk); #1;
      end
      chk(nm, 64'(res_q.size() >= n), 64'd1);
   endtask

   task automatic take(output logic [63:0] r, output int rc);
      r = 64'd0; rc = 0;
      if (res_q.size() > 0) begin
         r = res_q.pop_front();
         rc = res_cyc.pop_front();
      end
   endtask

   initial begin
      logic [63:0]  r;
      int           pc, rc;
      logic [511:0] eb;
      logic [2:0]   hdrs [6];
      hdrs = '{3'b101, 3'b111, 3'b111, 3'b110, 3'b100, 3'b100};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      chk("rst_result_wr", 64'(result_wr), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_counters", {cmd_cnt, res_cnt}, 64'd0);
      chk("rst_drop_alf", {31'd0, command_alf, drop_cnt}, 64'd0);
      chk("rst_version", 64'(cfg_regs[31:0]), 64'h2020_0924);
      chk_bus("rst_regs", {cfg_regs[511:32], 32'd0}, 512'd0);

      // write then read back register 5
      push1(mk(3'b100, 1'b0, 1'b1, 7'd1, 20'd5, 32'hDEAD_BEEF), pc);
      wait_res(1, "wr5_timeout");
      take(r, rc);
      chk("wr5_result", r, 64'h9810_0005_DEAD_BEEF);
      chk("wr5_latency", 64'(rc - pc), 64'd3);
      chk("wr5_reg", 64'(cfg_regs[191:160]), 64'hDEAD_BEEF);
      push1(mk(3'b100, 1'b0, 1'b0, 7'd1, 20'd5, 32'h0), pc);
      wait_res(1, "rd5_timeout");
      take(r, rc);
      chk("rd5_result", r, 64'h9010_0005_DEAD_BEEF);

      // version read and write to read-only register
      push1(mk(3'b100, 1'b0, 1'b0, 7'd1, 20'd0, 32'h0), pc);
      wait_res(1, "rd0_timeout");
      take(r, rc);
      chk("rd0_version", r, 64'h9010_0000_2020_0924);
      push1(mk(3'b100, 1'b0, 1'b1, 7'd1, 20'd1, 32'd5), pc);
      wait_res(1, "wr1_timeout");
      take(r, rc);
      chk("wr1_rejected", r, 64'h8810_0001_0000_0005);
      chk("wr1_cnt_live", 64'(cfg_regs[63:32]), 64'd4);

      // wrong module ID and out-of-range address
      push1(mk(3'b100, 1'b0, 1'b0, 7'd2, 20'd3, 32'h1234), pc);
      wait_res(1, "mdid_timeout");
      take(r, rc);
      chk("mdid_rejected", r, 64'h8020_0003_0000_1234);
      push1(mk(3'b100, 1'b0, 1'b1, 7'd1, 20'd16, 32'hABCD), pc);
      wait_res(1, "addr16_timeout");
      take(r, rc);
      chk("addr16_rejected", r, 64'h8810_0010_0000_ABCD);
      eb = 512'd0;
      eb[31:0] = 32'h2020_0924;
      eb[63:32] = 32'd6;
      eb[191:160] = 32'hDEAD_BEEF;
      chk_bus("addr16_regs", cfg_regs, eb);

      // overflow with downstream blocked
      repeat (4) @(posedge clk);
      #1 res_alf = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         cmd_wr = 1'b1;
         cmd = mk(hdrs[i], 1'b0, 1'b0, 7'd1, 20'(i + 2), 32'(i));
         @(negedge clk);
         if (i == 2) chk("ovf_alf_low", 64'(command_alf), 64'd0);
         if (i == 3) chk("ovf_alf_high", 64'(command_alf), 64'd1);
      end
      @(posedge clk); #1 cmd_wr = 1'b0;
      @(negedge clk); #1;
      chk("ovf_drops", 64'(drop_cnt), 64'd2);
      chk("ovf_accepted", 64'(cmd_cnt), 64'd10);
      chk("ovf_no_result", 64'(res_q.size()), 64'd0);
      @(posedge clk); #1 res_alf = 1'b0;
      wait_res(4, "ovf_timeout");
      repeat (10) @(negedge clk);
      #1 chk("ovf_count", 64'(res_q.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         take(r, rc);
         chk("ovf_result", r, mk(hdrs[i], 1'b1, 1'b0, 7'd1, 20'(i + 2),
                                 (i == 3) ? 32'hDEAD_BEEF : 32'd0));
      end
      res_q.delete(); res_cyc.delete();

      // backpressure raised while the first command executes
      @(posedge clk); #1;
      cmd_wr = 1'b1; cmd = mk(3'b101, 1'b0, 1'b1, 7'd1, 20'd6, 32'h66);
      @(posedge clk); #1;
      cmd = mk(3'b110, 1'b0, 1'b0, 7'd1, 20'd6, 32'h0);
      @(posedge clk); #1;
      cmd_wr = 1'b0; res_alf = 1'b1;
      repeat (8) @(negedge clk);
      #1 chk("bp_held", 64'(res_q.size()), 64'd1);
      take(r, rc);
      chk("bp_first", r, 64'hB810_0006_0000_0066);
      @(posedge clk); #1 res_alf = 1'b0;
      wait_res(1, "bp_timeout");
      take(r, rc);
      chk("bp_second", r, 64'hD010_0006_0000_0066);

      // reset while executing with two commands queued
      repeat (4) @(posedge clk);
      #1 res_alf = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         cmd_wr = 1'b1; cmd = mk(3'b100, 1'b0, 1'b1, 7'd1, 20'(i + 7), 32'hF00D);
      end
      @(posedge clk); #1 cmd_wr = 1'b0;
      repeat (2) @(posedge clk);
      #1 res_alf = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      #1;
      chk("mid_rst_wr", 64'(result_wr), 64'd0);
      chk("mid_rst_result", result, 64'd0);
      chk("mid_rst_cnts", {cmd_cnt, res_cnt}, 64'd0);
      chk("mid_rst_drop_alf", {31'd0, command_alf, drop_cnt}, 64'd0);
      chk_bus("mid_rst_regs", {cfg_regs[511:64], 64'd0}, 512'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      res_q.delete(); res_cyc.delete();
      repeat (15) @(negedge clk);
      #1 chk("post_rst_silent", 64'(res_q.size()), 64'd0);
      chk("post_rst_cmd_cnt", 64'(cmd_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cfg_cmd_responder.md
# cfg_cmd_responder

Endpoint of the 64-bit configuration command path: accepts commands produced by the control-packet-to-command converter, executes register reads/writes against a local register bank for one module ID (MDID), and returns 64-bit results in the same word format to the result-to-control-packet builder. It sits between the command and result sides of the NACP control path and also drives the configured register values out to the datapath.

## Interface
- MDID, 7'd1, module ID this responder owns (command bits [58:52])
- NUM_REGS, 16, register count (4..64); addresses 0..NUM_REGS-1 valid
- VERSION, 32'h2020_0924, value returned by register 0
- i_sys_clk  in  1  system clock; all logic on rising edge
- i_sys_rst  in  1  reset, asynchronous, active-high
- i_command_wr  in  1  command write strobe, one word per cycle
- i_command  in  64  [63:61] 101 first / 111 middle / 110 end / 100 first&end; [60] status; [59] 0 read, 1 write; [58:52] MDID; [51:32] address; [31:0] data
- o_command_alf  out  1  almost-full, high when FIFO count >= 3
- o_result_wr  out  1  result write strobe, one-cycle pulse
- o_result  out  64  result word, same format as command
- i_result_alf  in  1  downstream almost-full; blocks new command pops
- o_cfg_regs  out  NUM_REGS*32  flat register bank; reg n at [n*32+31:n*32]
- o_cmd_cnt  out  32  commands accepted into FIFO
- o_res_cnt  out  32  results issued
- o_drop_cnt  out  32  commands dropped (write while FIFO full)

## Operation
- 4-entry command FIFO; i_command_wr with FIFO not full -> push, o_cmd_cnt++. FIFO full -> word dropped, o_drop_cnt++, FIFO unchanged.
- Simultaneous push and pop on a full FIFO: pop happens first in the same cycle, so push accepted (no drop).
- Register map: reg 0 read-only = VERSION; reg 1 read-only = o_cmd_cnt snapshot at execute; regs 2..NUM_REGS-1 read/write, reset 0. o_cfg_regs slices 0/1 reflect VERSION/o_cmd_cnt live.
- FSM states IDLE, EXEC, RESP:
  - IDLE: FIFO non-empty and i_result_alf low -> pop head into cmd_r, go EXEC; else stay.
  - EXEC: decode cmd_r; build res_r; perform register write if legal; go RESP.
  - RESP: o_result_wr=1, o_result=res_r, o_res_cnt++; go IDLE.
- Success condition: cmd_r[58:52]==MDID and cmd_r[51:32] < NUM_REGS and not (write to address 0 or 1).
- Result word: [63:61] and [59:32] copied from command; [60]=1 on success, 0 on failure; [31:0] = register value on successful read, otherwise command data echoed.
- Failed write: no register changes. MDID mismatch: still answered (status 0), never silently consumed.
- Counters 32-bit, wrap from FFFF_FFFF to 0.

## Timing
- Reset (async assert, sync-to-clock release): FIFO empty, FSM IDLE, o_result_wr=0, o_result=0, o_command_alf=0, all counters 0, regs 2..N-1 = 0.
- Latency: command pushed in cycle c -> o_result_wr high in cycle c+3 (FIFO visible c+1, EXEC c+2, RESP c+3). Register write visible on o_cfg_regs in cycle c+3.
- Throughput: one command per 3 cycles; back-to-back results separated by at least 2 idle cycles.
- i_result_alf sampled only in IDLE; a command already in EXEC/RESP always completes. Downstream must tolerate 1 result after raising alf.
- o_command_alf combinational from registered FIFO count; asserts the cycle after 3rd entry lands.
- Reset mid-operation: in-flight command and FIFO contents discarded, no result emitted.

## Test plan
- Write then read: push {3'b100,1'b0,1'b1,7'd1,20'd5,32'hDEAD_BEEF}, then read addr 5 -> results {…[60]=1, data DEAD_BEEF}, second result data DEAD_BEEF, o_cfg_regs[191:160]=DEAD_BEEF, first result exactly 3 cycles after push.
- Version/RO: read addr 0 -> data 2020_0924, status 1; write addr 1 value 5 -> status 0, data 5 echoed, counter unchanged.
- Illegal: MDID 7'd2 read addr 3 -> status 0, data echoed; addr 16 (NUM_REGS=16) write -> status 0, no register change.
- Overflow: 6 pushes in consecutive cycles with i_result_alf=1 -> 4 accepted, o_drop_cnt=2, o_command_alf high from 4th cycle; release alf -> exactly 4 results, in order, header bits preserved.
- Backpressure: raise i_result_alf while a command is in EXEC -> that result still issued, next command held until alf low.
- Reset mid-stream: assert i_sys_rst while FSM in EXEC with 2 queued -> all outputs/counters 0 immediately, no o_result_wr after release.
